// File: rtl/mul_pkg.sv
// Shared constants and types for the iterative radix-4 Booth multiplier.
package mul_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NITER = XLEN / 2 + 1;
    localparam int unsigned EXT_W = XLEN + 2;
    localparam int unsigned ACC_W = 2 * EXT_W;
    localparam int unsigned CNT_W = $clog2(NITER + 1);

    typedef logic [1:0] mul_state_t;

    localparam mul_state_t StIdle = 2'd0;
    localparam mul_state_t StBusy = 2'd1;
    localparam mul_state_t StDone = 2'd2;
    localparam mul_state_t StHold = 2'd3;

    // Three overlapping multiplier bits {b(2i+1), b(2i), b(2i-1)} select one Booth digit.
    typedef logic [2:0] booth_bits_t;

endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth partial-product selector: three multiplier bits pick 0, +-M or +-2M.
module booth_r4_sel
    import mul_pkg::*;
(
    input  booth_bits_t      bits,
    input  logic [ACC_W-1:0] mcand,
    output logic [ACC_W-1:0] pp
);

    always_comb begin
        pp = '0;
        unique case (bits)
            3'b000, 3'b111: pp = '0;
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = -(mcand << 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
    end

endmodule

// File: rtl/mul_iter.sv
// Iterative radix-4 Booth multiplier with level-request / one-cycle complete handshake.
// Define MUL_EARLY_OUT_EN to finish as soon as all remaining Booth digits are zero.
module mul_iter
    import mul_pkg::*;
(
    input  logic              mul_clk,
    input  logic              resetn,
    input  logic              mul,
    input  logic              mul_signed,
    input  logic [XLEN-1:0]   x,
    input  logic [XLEN-1:0]   y,
    output logic              busy,
    output logic              complete,
    output logic [2*XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] NiterCnt = CNT_W'(NITER);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    mul_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    mcand_q, mcand_d;
    logic [EXT_W:0]      mplier_q, mplier_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [2*XLEN-1:0]   result_q, result_d;

    logic [ACC_W-1:0]    x_ext;
    logic [EXT_W:0]      y_ext;
    logic [ACC_W-1:0]    pp;
    logic [ACC_W-1:0]    acc_sum;
    logic                last_digit;

    // Two extra zero bits in the unsigned case keep the top Booth digit non-negative.
    assign x_ext   = {{(ACC_W - XLEN){mul_signed & x[XLEN-1]}}, x};
    assign y_ext   = {{2{mul_signed & y[XLEN-1]}}, y, 1'b0};
    assign acc_sum = acc_q + pp;

    booth_r4_sel u_sel (
        .bits  (mplier_q[2:0]),
        .mcand (mcand_q),
        .pp    (pp)
    );

`ifdef MUL_EARLY_OUT_EN
    logic [EXT_W-2:0] rest;
    assign rest       = mplier_q[EXT_W:2];
    assign last_digit = (cnt_q == CntOne) || (&rest) || !(|rest);
`else
    assign last_digit = (cnt_q == CntOne);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                if (mul) begin
                    mcand_d  = x_ext;
                    mplier_d = y_ext;
                    acc_d    = '0;
                    cnt_d    = NiterCnt;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                if (!mul) begin
                    state_d = StIdle;
                end else begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << 2;
                    // Sign-fill keeps the remaining-bits-equal test valid after each shift.
                    mplier_d = {{2{mplier_q[EXT_W]}}, mplier_q[EXT_W:2]};
                    cnt_d    = cnt_q - CntOne;
                    if (last_digit) begin
                        result_d = acc_sum[2*XLEN-1:0];
                        state_d  = StDone;
                    end
                end
            end
            StDone: state_d = mul ? StHold : StIdle;
            StHold: begin
                if (!mul) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge mul_clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy     = (state_q == StBusy);
    assign complete = (state_q == StDone);
    assign result   = result_q;

endmodule
